ad_serdes_tx_gearbox: RTL and testbench

- Technology-independent, fabric-based transmit gearbox. Next generation of the per-lane output serializer.
- Accepts one SERDES_FACTOR-slot parallel word for all lanes through a valid/ready handshake. Emits 1 slot per clock (SDR) or 2 slots per clock (DDR, feeding an ODDR pair) on every lane.
- Adds features the primitive-based serializer lacks: back-pressure, a one-word skid buffer, idle-pattern fill with underflow accounting, and a word-aligned training-pattern mode.
- Sits between the DAC/LVDS data path and the output buffer/ODDR stage.

---
 rtl/ad_serdes_tx_gearbox_if.sv | 24 ++
 rtl/ad_serdes_tx_gearbox.sv | 120 ++++++++++++
 tb/tb_ad_serdes_tx_gearbox.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_serdes_tx_gearbox_if.sv
// Parallel word handshake between the DAC/LVDS data path and the transmit gearbox.
// Latency: none; this only bundles wires.
// Backpressure: a word transfers on a rising edge where s_valid and s_ready are both high.
interface ad_serdes_tx_gearbox_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int SERDES_FACTOR = 8
);
    // Slot k sits at [k*DATA_WIDTH +: DATA_WIDTH]; slot 0 goes out first.
    logic [DATA_WIDTH*SERDES_FACTOR-1:0] s_data;
    logic                                s_valid;
    logic                                s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/ad_serdes_tx_gearbox.sv
// Fabric transmit gearbox: one parallel word in, 1 (SDR) or 2 (DDR) slots per lane per clock out.
// Latency: slot 0 appears the cycle after the load edge; accept-to-first-slot is 1..N+1 cycles.
// Backpressure: one-word hold buffer; s_ready is low only while hold is full off a load edge.
module ad_serdes_tx_gearbox #(
    parameter int DATA_WIDTH    = 16,
    parameter int SERDES_FACTOR = 8,
    parameter bit DDR_OR_SDR_N  = 1'b1,
    parameter bit IDLE_SLOT     = 1'b0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    ad_serdes_tx_gearbox_if.slave    s,
    input  logic                     train_en,
    input  logic [SERDES_FACTOR-1:0] train_pattern,
    input  logic                     underflow_clr,
    output logic [DATA_WIDTH-1:0]    data_out_0,
    output logic [DATA_WIDTH-1:0]    data_out_1,
    output logic                     underflow,
    output logic [CNT_WIDTH-1:0]     underflow_cnt
);
    localparam int B      = DDR_OR_SDR_N ? 2 : 1;
    localparam int N      = SERDES_FACTOR / B;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam int WORD_W = DATA_WIDTH * SERDES_FACTOR;
    localparam int STEP_W = B * DATA_WIDTH;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);
    localparam logic [WORD_W-1:0] IDLE_WORD = {WORD_W{IDLE_SLOT}};
    // Slots vacated at the top of the shift register refill with the idle level.
    localparam logic [WORD_W-1:0] FILL_MASK = ~({WORD_W{1'b1}} >> STEP_W);

    if (SERDES_FACTOR < 2 || SERDES_FACTOR > 16 ||
        (DDR_OR_SDR_N && (SERDES_FACTOR % 2 != 0))) begin : g_bad_param
        $error("ad_serdes_tx_gearbox: illegal SERDES_FACTOR for the selected rate");
    end

    logic [BEAT_W-1:0] beat_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] hold_q;
    logic              hold_full_q;
    logic              run_q;
    logic [WORD_W-1:0] train_word;
    logic              load_edge;
    logic              load_now;
    logic              idle_load;
    logic              accept;

    // Word boundary: every load_edge reloads the shift register (training, hold or idle).
    assign load_edge = (beat_q == LAST_BEAT);
    // Hold drains into shift only when training is not overriding this boundary.
    assign load_now  = load_edge && !train_en;
    assign idle_load = load_now && !hold_full_q;
    // run_q keeps ready low through reset and rises on the first edge after release.
    assign s.s_ready = run_q && (!hold_full_q || load_now);
    assign accept    = s.s_valid && s.s_ready;

    // Replicate training bit k across every lane of slot k.
    always_comb begin
        train_word = '0;
        for (int k = 0; k < SERDES_FACTOR; k++) begin
            train_word[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{train_pattern[k]}};
        end
    end

    // Beat counter, shift register and one-word hold buffer; data always flows hold -> shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q      <= LAST_BEAT;
            shift_q     <= IDLE_WORD;
            hold_q      <= IDLE_WORD;
            hold_full_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            beat_q <= load_edge ? '0 : beat_q + BEAT_W'(1);

            if (load_edge) begin
                if (train_en) begin
                    shift_q <= train_word;
                end else if (hold_full_q) begin
                    shift_q <= hold_q;
                end else begin
                    shift_q <= IDLE_WORD;
                end
            end else begin
                shift_q <= (shift_q >> STEP_W) | (IDLE_WORD & FILL_MASK);
            end

            if (accept) begin
                hold_q <= s.s_data;
            end
            if (load_now) begin
                hold_full_q <= accept;
            end else if (accept) begin
                hold_full_q <= 1'b1;
            end
        end
    end

    // Underflow pulse and saturating idle-word counter; a clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            underflow <= idle_load;
            if (underflow_clr) begin
                underflow_cnt <= '0;
            end else if (idle_load && (underflow_cnt != {CNT_WIDTH{1'b1}})) begin
                underflow_cnt <= underflow_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs come straight from shift register flops; no input reaches them combinationally.
    assign data_out_0 = shift_q[0 +: DATA_WIDTH];
    assign data_out_1 = (B == 2) ? shift_q[DATA_WIDTH +: DATA_WIDTH] : shift_q[0 +: DATA_WIDTH];

endmodule

// File: tb/tb_ad_serdes_tx_gearbox.sv
// Directed bench for the transmit gearbox: a DDR 2-lane x8 instance and an SDR 2-lane x4 instance.
// Latency: expectations are per cycle, sampled 1 time unit after each rising edge.
// Backpressure: the bench source holds s_valid and advances only on observed handshakes.
module tb_ad_serdes_tx_gearbox;
    logic       clk = 1'b0;
    logic       rstn;
    logic       train_en;
    logic [7:0] train_pattern;
    logic [3:0] train_pattern_s;
    logic       underflow_clr;

    logic [1:0]  do0_d, do1_d, do0_s, do1_s;
    logic        uf_d, uf_s;
    logic [15:0] cnt_d;
    logic [1:0]  cnt_s;

    int   checks = 0;
    int   errors = 0;
    logic acc_d, acc_s;

    // Lane0 = 8'hB2 per beat: even slots 0,0,1,0 and odd slots 1,0,1,1 (index = beat).
    logic [3:0] l0_even = 4'b0100;
    logic [3:0] l0_odd  = 4'b1101;
    // Training 8'hA5 per beat: even slots 1,1,0,0 and odd slots 0,0,1,1.
    logic [3:0] t_even  = 4'b0011;
    logic [3:0] t_odd   = 4'b1100;
    // SDR word lane0 4'b0110, lane1 4'b1001: per cycle {lane1,lane0} = 10,01,01,10.
    logic [7:0] sdr_exp = 8'b10_01_01_10;

    ad_serdes_tx_gearbox_if #(.DATA_WIDTH(2), .SERDES_FACTOR(8)) d_if ();
    ad_serdes_tx_gearbox_if #(.DATA_WIDTH(2), .SERDES_FACTOR(4)) s_if ();

    ad_serdes_tx_gearbox #(
        .DATA_WIDTH(2), .SERDES_FACTOR(8), .DDR_OR_SDR_N(1'b1), .IDLE_SLOT(1'b0), .CNT_WIDTH(16)
    ) u_ddr (
        .clk(clk), .rstn(rstn), .s(d_if), .train_en(train_en), .train_pattern(train_pattern),
        .underflow_clr(underflow_clr), .data_out_0(do0_d), .data_out_1(do1_d),
        .underflow(uf_d), .underflow_cnt(cnt_d)
    );

    ad_serdes_tx_gearbox #(
        .DATA_WIDTH(2), .SERDES_FACTOR(4), .DDR_OR_SDR_N(1'b0), .IDLE_SLOT(1'b0), .CNT_WIDTH(2)
    ) u_sdr (
        .clk(clk), .rstn(rstn), .s(s_if), .train_en(train_en), .train_pattern(train_pattern_s),
        .underflow_clr(underflow_clr), .data_out_0(do0_s), .data_out_1(do1_s),
        .underflow(uf_s), .underflow_cnt(cnt_s)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] make_word8(input logic [7:0] lane0, input logic [7:0] lane1);
        logic [15:0] w;
        for (int k = 0; k < 8; k++) begin
            w[2*k]   = lane0[k];
            w[2*k+1] = lane1[k];
        end
        return w;
    endfunction

    function automatic logic [7:0] make_word4(input logic [3:0] lane0, input logic [3:0] lane1);
        logic [7:0] w;
        for (int k = 0; k < 4; k++) begin
            w[2*k]   = lane0[k];
            w[2*k+1] = lane1[k];
        end
        return w;
    endfunction

    // Record handshakes at the falling edge, then land 1 unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        acc_d = d_if.s_valid && d_if.s_ready;
        acc_s = s_if.s_valid && s_if.s_ready;
        @(posedge clk);
        #1;
    endtask

    // Reset both instances; returns 1 unit after the edge preceding the first idle load.
    task automatic do_reset();
        rstn          = 1'b0;
        d_if.s_valid  = 1'b0;
        d_if.s_data   = '0;
        s_if.s_valid  = 1'b0;
        s_if.s_data   = '0;
        train_en      = 1'b0;
        underflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_uf;
        rstn            = 1'b0;
        d_if.s_valid    = 1'b0;
        d_if.s_data     = '0;
        s_if.s_valid    = 1'b0;
        s_if.s_data     = '0;
        train_en        = 1'b0;
        train_pattern   = 8'h00;
        train_pattern_s = 4'h0;
        underflow_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({do0_d, do1_d} !== 4'b0000) begin errors++; $display("FAIL reset_out: got %b expected 0000", {do0_d, do1_d}); end
        checks++; if (uf_d !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b expected 0", uf_d); end
        checks++; if (cnt_d !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_d); end
        checks++; if (d_if.s_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", d_if.s_ready); end
        rstn = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_uf = (c % 4 == 1);
            checks++; if ({do0_d, do1_d} !== 4'b0000) begin errors++; $display("FAIL idle_out c=%0d: got %b expected 0000", c, {do0_d, do1_d}); end
            checks++; if (uf_d !== exp_uf) begin errors++; $display("FAIL idle_uf c=%0d: got %b expected %b", c, uf_d, exp_uf); end
            checks++; if (d_if.s_ready !== 1'b1) begin errors++; $display("FAIL idle_rdy c=%0d: got %b expected 1", c, d_if.s_ready); end
        end
        checks++; if (cnt_d !== 16'd3) begin errors++; $display("FAIL idle_cnt: got %0d expected 3", cnt_d); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int j, b;
        logic [1:0] e0, e1;
        logic exp_rdy;
        do_reset();
        d_if.s_valid = 1'b1;
        d_if.s_data  = make_word8(8'hB2, 8'hFF);
        for (int c = 1; c <= 44; c++) begin
            step();
            if (c <= 4) begin
                e0 = 2'b00; e1 = 2'b00;
            end else begin
                j  = (c - 1) / 4;
                b  = (c - 1) % 4;
                e0 = {(j % 2 == 1), l0_even[b]};
                e1 = {(j % 2 == 1), l0_odd[b]};
            end
            exp_rdy = (c == 1) || (c % 4 == 0) || (c >= 41);
            checks++; if (do0_d !== e0) begin errors++; $display("FAIL b2b_do0 c=%0d: got %b expected %b", c, do0_d, e0); end
            checks++; if (do1_d !== e1) begin errors++; $display("FAIL b2b_do1 c=%0d: got %b expected %b", c, do1_d, e1); end
            checks++; if (uf_d !== (c == 1)) begin errors++; $display("FAIL b2b_uf c=%0d: got %b expected %b", c, uf_d, (c == 1)); end
            checks++; if (d_if.s_ready !== exp_rdy) begin errors++; $display("FAIL b2b_rdy c=%0d: got %b expected %b", c, d_if.s_ready, exp_rdy); end
            if (acc_d) begin
                sent++;
                if (sent >= 10) d_if.s_valid = 1'b0;
                else d_if.s_data = make_word8(8'hB2, (sent % 2 == 0) ? 8'hFF : 8'h00);
            end
        end
        checks++; if (sent != 10) begin errors++; $display("FAIL b2b_sent: got %0d expected 10", sent); end
        checks++; if (cnt_d !== 16'd1) begin errors++; $display("FAIL b2b_cnt: got %0d expected 1", cnt_d); end
    endtask

    task automatic test_train();
        int sent = 0;
        int b;
        logic [1:0] e0, e1;
        logic exp_rdy, exp_uf;
        do_reset();
        train_pattern = 8'hA5;
        d_if.s_valid  = 1'b1;
        d_if.s_data   = make_word8(8'hB2, 8'hFF);
        for (int c = 1; c <= 21; c++) begin
            step();
            b = (c - 1) % 4;
            if (c >= 5 && c <= 8) begin
                e0 = {1'b1, l0_even[b]}; e1 = {1'b1, l0_odd[b]};
            end else if (c >= 9 && c <= 16) begin
                e0 = {2{t_even[b]}}; e1 = {2{t_odd[b]}};
            end else if (c >= 17 && c <= 20) begin
                e0 = {1'b0, l0_even[b]}; e1 = {1'b0, l0_odd[b]};
            end else begin
                e0 = 2'b00; e1 = 2'b00;
            end
            exp_rdy = (c == 1) || (c == 4) || (c >= 16);
            exp_uf  = (c == 1) || (c == 21);
            checks++; if (do0_d !== e0) begin errors++; $display("FAIL train_do0 c=%0d: got %b expected %b", c, do0_d, e0); end
            checks++; if (do1_d !== e1) begin errors++; $display("FAIL train_do1 c=%0d: got %b expected %b", c, do1_d, e1); end
            checks++; if (uf_d !== exp_uf) begin errors++; $display("FAIL train_uf c=%0d: got %b expected %b", c, uf_d, exp_uf); end
            checks++; if (d_if.s_ready !== exp_rdy) begin errors++; $display("FAIL train_rdy c=%0d: got %b expected %b", c, d_if.s_ready, exp_rdy); end
            if (acc_d) begin
                sent++;
                if (sent == 1) d_if.s_data = make_word8(8'hB2, 8'h00);
                else d_if.s_valid = 1'b0;
            end
            if (c == 6)  train_en = 1'b1;
            if (c == 14) train_en = 1'b0;
        end
    endtask

    task automatic test_sdr();
        int b;
        logic [1:0] e;
        do_reset();
        s_if.s_valid = 1'b1;
        s_if.s_data  = make_word4(4'b0110, 4'b1001);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (acc_s) s_if.s_valid = 1'b0;
            b = c - 5;
            e = (c >= 5 && c <= 8) ? sdr_exp[b*2 +: 2] : 2'b00;
            checks++; if (do0_s !== e) begin errors++; $display("FAIL sdr_do0 c=%0d: got %b expected %b", c, do0_s, e); end
            checks++; if (do1_s !== e) begin errors++; $display("FAIL sdr_do1 c=%0d: got %b expected %b", c, do1_s, e); end
            checks++; if (uf_s !== (c == 1 || c == 9)) begin errors++; $display("FAIL sdr_uf c=%0d: got %b expected %b", c, uf_s, (c == 1 || c == 9)); end
        end
    endtask

    task automatic test_underflow_sat();
        int n;
        logic [1:0] es;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            n  = (c + 3) / 4;
            es = (n > 3) ? 2'd3 : 2'(n);
            checks++; if (cnt_s !== es) begin errors++; $display("FAIL sat_cnt2 c=%0d: got %0d expected %0d", c, cnt_s, es); end
            checks++; if (cnt_d !== 16'(n)) begin errors++; $display("FAIL sat_cnt16 c=%0d: got %0d expected %0d", c, cnt_d, n); end
        end
    endtask

    task automatic test_underflow_clr();
        int ec;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c < 9)       ec = (c + 3) / 4;
            else if (c < 13) ec = 0;
            else             ec = 1;
            checks++; if (cnt_d !== 16'(ec)) begin errors++; $display("FAIL clr_cnt c=%0d: got %0d expected %0d", c, cnt_d, ec); end
            checks++; if (uf_d !== (c % 4 == 1)) begin errors++; $display("FAIL clr_uf c=%0d: got %b expected %b", c, uf_d, (c % 4 == 1)); end
            if (c == 8) underflow_clr = 1'b1;
            if (c == 9) underflow_clr = 1'b0;
        end
    endtask

    task automatic test_reset_mid_word();
        int sent = 0;
        do_reset();
        d_if.s_valid = 1'b1;
        d_if.s_data  = make_word8(8'hB2, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (acc_d) begin
                sent++;
                if (sent == 1) d_if.s_data = make_word8(8'hFF, 8'hFF);
                else d_if.s_valid = 1'b0;
            end
        end
        checks++; if ({do0_d, do1_d} !== 4'b1010) begin errors++; $display("FAIL mid_pre: got %b expected 1010", {do0_d, do1_d}); end
        #3;
        rstn = 1'b0;
        #1;
        checks++; if ({do0_d, do1_d} !== 4'b0000) begin errors++; $display("FAIL mid_async_out: got %b expected 0000", {do0_d, do1_d}); end
        checks++; if (cnt_d !== 16'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d expected 0", cnt_d); end
        checks++; if (d_if.s_ready !== 1'b0) begin errors++; $display("FAIL mid_async_rdy: got %b expected 0", d_if.s_ready); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++; if ({do0_d, do1_d} !== 4'b0000) begin errors++; $display("FAIL mid_after_out c=%0d: got %b expected 0000", c, {do0_d, do1_d}); end
            checks++; if (uf_d !== (c % 4 == 1)) begin errors++; $display("FAIL mid_after_uf c=%0d: got %b expected %b", c, uf_d, (c % 4 == 1)); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_train();
        test_sdr();
        test_underflow_sat();
        test_underflow_clr();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
